// File: rtl/func_eval_sched.sv
// Scheduler sharing one 7-input combinational evaluator between two requesters
// and an exhaustive 128-vector sweep that counts the evaluator's ones.
module func_eval_sched #(
    parameter bit RR_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic [6:0] vec0,
    output logic       gnt0,
    input  logic       req1,
    input  logic [6:0] vec1,
    output logic       gnt1,
    input  logic       sweep_start,
    output logic [6:0] eval_vec,
    input  logic       eval_y,
    output logic       rsp_valid,
    output logic       rsp_id,
    output logic       rsp_y,
    output logic       sweep_busy,
    output logic       sweep_done,
    output logic [7:0] ones_cnt
);

    localparam int unsigned VEC_W = 7;
    localparam int unsigned CNT_W = 8;
    localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(127);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        SWEEP = 2'd2
    } state_t;

    state_t state;
    logic   last_id;
    logic   win_id;
    logic   grant_any;

    // Arbitration: grants only from IDLE and only when no sweep is being started.
    always_comb begin
        win_id    = 1'b0;
        grant_any = 1'b0;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        if (rst_n && (state == IDLE) && !sweep_start) begin
            if (req0 && req1) begin
                win_id = RR_EN ? ~last_id : 1'b0;
            end else begin
                win_id = req1;
            end
            grant_any = req0 | req1;
            gnt0      = grant_any & ~win_id;
            gnt1      = grant_any & win_id;
        end
    end

    // During a sweep eval_vec doubles as the sweep index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            eval_vec   <= '0;
            last_id    <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_y      <= 1'b0;
            sweep_busy <= 1'b0;
            sweep_done <= 1'b0;
            ones_cnt   <= '0;
        end else begin
            rsp_valid  <= 1'b0;
            sweep_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (sweep_start) begin
                        state      <= SWEEP;
                        eval_vec   <= '0;
                        ones_cnt   <= '0;
                        sweep_busy <= 1'b1;
                    end else if (grant_any) begin
                        state    <= EVAL;
                        eval_vec <= win_id ? vec1 : vec0;
                        last_id  <= win_id;
                    end
                end
                EVAL: begin
                    rsp_valid <= 1'b1;
                    rsp_y     <= eval_y;
                    rsp_id    <= last_id;
                    state     <= IDLE;
                end
                SWEEP: begin
                    ones_cnt <= ones_cnt + CNT_W'(eval_y);
                    if (eval_vec != LAST_VEC) begin
                        eval_vec <= eval_vec + VEC_W'(1);
                    end else begin
                        state      <= IDLE;
                        sweep_busy <= 1'b0;
                        sweep_done <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_func_eval_sched.sv
// Self-checking bench for func_eval_sched: vector table, multi-cycle corner
// sequences and a randomized run against a transaction-level reference model.
module tb_func_eval_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1, sweep_start;
    logic [6:0] vec0, vec1;

    logic       gnt0, gnt1, rsp_valid, rsp_id, rsp_y, sweep_busy, sweep_done, eval_y;
    logic [6:0] eval_vec;
    logic [7:0] ones_cnt;

    logic       f_gnt0, f_gnt1, f_rsp_valid, f_rsp_id, f_rsp_y, f_sweep_busy, f_sweep_done, f_eval_y;
    logic [6:0] f_eval_vec;
    logic [7:0] f_ones_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Evaluator under test: y = abc | ~d | (~e & f & g), bit 6 = a.
    function automatic logic ref_y(input logic [6:0] v);
        return (v[6] & v[5] & v[4]) | ~v[3] | (~v[2] & v[1] & v[0]);
    endfunction

    assign eval_y   = ref_y(eval_vec);
    assign f_eval_y = ref_y(f_eval_vec);

    func_eval_sched #(.RR_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .vec0(vec0), .gnt0(gnt0),
        .req1(req1), .vec1(vec1), .gnt1(gnt1),
        .sweep_start(sweep_start), .eval_vec(eval_vec), .eval_y(eval_y),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_y(rsp_y),
        .sweep_busy(sweep_busy), .sweep_done(sweep_done), .ones_cnt(ones_cnt)
    );

    func_eval_sched #(.RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .vec0(vec0), .gnt0(f_gnt0),
        .req1(req1), .vec1(vec1), .gnt1(f_gnt1),
        .sweep_start(sweep_start), .eval_vec(f_eval_vec), .eval_y(f_eval_y),
        .rsp_valid(f_rsp_valid), .rsp_id(f_rsp_id), .rsp_y(f_rsp_y),
        .sweep_busy(f_sweep_busy), .sweep_done(f_sweep_done), .ones_cnt(f_ones_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    typedef struct {
        logic       id;
        logic [6:0] vec;
        logic       y;
    } vec_rec_t;

    typedef struct {
        int   due;
        logic id;
        logic y;
    } exp_rsp_t;

    vec_rec_t   tbl [8];
    exp_rsp_t   q [$];
    exp_rsp_t   e;
    logic       p0, p1, last_win;
    int         last_gnt_cyc, vec_due, max_wait, wait0, wait1;
    logic [6:0] vec_exp;

    // One randomized cycle: drive new requests (if allowed), then compare against the model.
    task automatic rand_cycle(input bit allow_new);
        logic exp_win;
        step();
        sweep_start = 1'b0;
        if (allow_new) begin
            if (!p0 && $urandom_range(0, 3) == 0) begin p0 = 1'b1; vec0 = 7'($urandom); end
            if (!p1 && $urandom_range(0, 3) == 0) begin p1 = 1'b1; vec1 = 7'($urandom); end
            if ($urandom_range(0, 199) == 0) sweep_start = 1'b1;
        end
        req0 = p0;
        req1 = p1;
        sample();
        if (gnt0 | gnt1) begin
            check("gnt_exclusive", 32'(gnt0 & gnt1), 0);
            check("gnt_has_req", 32'((gnt0 & !p0) | (gnt1 & !p1)), 0);
            exp_win = (p0 && p1) ? ~last_win : p1;
            check("rr_winner", 32'(gnt1), 32'(exp_win));
            check("grant_spacing", 32'(cyc - last_gnt_cyc >= 2), 1);
            e.due = cyc + 2;
            e.id  = gnt1;
            e.y   = ref_y(gnt1 ? vec1 : vec0);
            q.push_back(e);
            vec_due      = cyc + 1;
            vec_exp      = gnt1 ? vec1 : vec0;
            last_win     = gnt1;
            last_gnt_cyc = cyc;
            if (gnt0) p0 = 1'b0;
            if (gnt1) p1 = 1'b0;
        end
        if (vec_due == cyc) check("rand_eval_vec", 32'(eval_vec), 32'(vec_exp));
        if (rsp_valid) begin
            check("rsp_not_in_sweep", 32'(sweep_busy), 0);
            if (q.size() == 0) begin
                check("rsp_unexpected", 1, 0);
            end else begin
                e = q.pop_front();
                check("rsp_due", 32'(cyc), 32'(e.due));
                check("rsp_id", 32'(rsp_id), 32'(e.id));
                check("rsp_y", 32'(rsp_y), 32'(e.y));
            end
        end else if (q.size() != 0 && q[0].due <= cyc) begin
            check("rsp_missing", 0, 1);
            void'(q.pop_front());
        end
        if (sweep_done) check("rand_sweep_ones", 32'(ones_cnt), 79);
        wait0 = p0 ? wait0 + 1 : 0;
        wait1 = p1 ? wait1 + 1 : 0;
        if (wait0 > max_wait) max_wait = wait0;
        if (wait1 > max_wait) max_wait = wait1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int  busy_n, done_n, bad_n;
        bit  seen, found;

        tbl[0] = '{1'b1, 7'h00, 1'b1};
        tbl[1] = '{1'b0, 7'h7F, 1'b1};
        tbl[2] = '{1'b1, 7'h08, 1'b0};
        tbl[3] = '{1'b0, 7'h70, 1'b1};
        tbl[4] = '{1'b1, 7'h0B, 1'b1};
        tbl[5] = '{1'b0, 7'h0F, 1'b0};
        tbl[6] = '{1'b1, 7'h68, 1'b0};
        tbl[7] = '{1'b0, 7'h6B, 1'b1};

        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; vec0 = '0; vec1 = '0; sweep_start = 1'b0;
        #2;
        check("reset_outputs", 32'({eval_vec, gnt0, gnt1, rsp_valid, rsp_id, rsp_y,
                                    sweep_busy, sweep_done, ones_cnt}), 0);
        check("reset_outputs_fp", 32'({f_eval_vec, f_gnt0, f_gnt1, f_rsp_valid, f_rsp_id, f_rsp_y,
                                       f_sweep_busy, f_sweep_done, f_ones_cnt}), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Tie after reset: requester 0 first, then strict alternation; fixed priority always 0.
        step();
        req0 = 1'b1; req1 = 1'b1; vec0 = 7'h7F; vec1 = 7'h08;
        for (int k = 0; k < 8; k++) begin
            sample();
            if (k % 2 == 0) begin
                check("tie_gnt0", 32'(gnt0), 32'((k / 2) % 2 == 0));
                check("tie_gnt1", 32'(gnt1), 32'((k / 2) % 2 == 1));
                check("fp_gnt0", 32'(f_gnt0), 1);
                check("fp_gnt1", 32'(f_gnt1), 0);
            end else begin
                check("tie_no_grant", 32'({gnt0, gnt1, f_gnt0, f_gnt1}), 0);
            end
            if (k >= 2 && k % 2 == 0) begin
                check("tie_rsp_valid", 32'(rsp_valid), 1);
                check("tie_rsp_id", 32'(rsp_id), 32'(((k / 2) - 1) % 2));
                check("tie_rsp_y", 32'(rsp_y), 32'(((k / 2) - 1) % 2 == 0));
            end
            step();
        end
        req0 = 1'b0; req1 = 1'b0;
        step();
        step();

        // Single-request table: gnt at N, eval_vec at N+1, response at N+2.
        for (int i = 0; i < 8; i++) begin
            step();
            if (tbl[i].id) begin req1 = 1'b1; vec1 = tbl[i].vec; end
            else           begin req0 = 1'b1; vec0 = tbl[i].vec; end
            sample();
            check("tbl_gnt0", 32'(gnt0), 32'(!tbl[i].id));
            check("tbl_gnt1", 32'(gnt1), 32'(tbl[i].id));
            step();
            req0 = 1'b0; req1 = 1'b0;
            sample();
            check("tbl_eval_vec", 32'(eval_vec), 32'(tbl[i].vec));
            check("tbl_no_early_rsp", 32'(rsp_valid), 0);
            step();
            sample();
            check("tbl_rsp_valid", 32'(rsp_valid), 1);
            check("tbl_rsp_id", 32'(rsp_id), 32'(tbl[i].id));
            check("tbl_rsp_y", 32'(rsp_y), 32'(tbl[i].y));
        end

        // Collision: sweep wins over req0, mid-sweep start ignored, req0 granted on done cycle.
        step();
        sweep_start = 1'b1; req0 = 1'b1; vec0 = 7'h7F;
        sample();
        check("collide_no_gnt0", 32'(gnt0), 0);
        busy_n = 0; done_n = 0; bad_n = 0; seen = 1'b0;
        for (int t = 0; t < 300 && !seen; t++) begin
            step();
            sweep_start = (t == 40);
            sample();
            if (sweep_busy) begin
                if (eval_vec != 7'(busy_n) || gnt0 || gnt1 || rsp_valid) bad_n++;
                busy_n++;
            end
            if (sweep_done) begin
                seen = 1'b1;
                done_n++;
                check("gnt0_after_sweep", 32'(gnt0), 1);
            end
        end
        sweep_start = 1'b0;
        check("sweep_seen_done", 32'(seen), 1);
        check("sweep_busy_cycles", 32'(busy_n), 128);
        check("sweep_step_errors", 32'(bad_n), 0);
        check("sweep_ones", 32'(ones_cnt), 79);
        step();
        req0 = 1'b0;
        sample();
        check("post_sweep_eval_vec", 32'(eval_vec), 32'h7F);
        step();
        sample();
        check("post_sweep_rsp", 32'({rsp_valid, rsp_id, rsp_y}), 32'(3'b101));
        for (int t = 0; t < 6; t++) begin
            step();
            sample();
            if (sweep_done) done_n++;
        end
        check("sweep_single_done", 32'(done_n), 1);
        check("ones_hold", 32'(ones_cnt), 79);

        // Reset at sweep index 60 aborts silently; a fresh sweep then completes.
        step();
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        found = 1'b0;
        for (int t = 0; t < 200; t++) begin
            sample();
            if (sweep_busy && eval_vec == 7'd60) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check("reach_idx60", 32'(found), 1);
        rst_n = 1'b0;
        #1;
        check("abort_outputs", 32'({eval_vec, gnt0, gnt1, rsp_valid, rsp_id, rsp_y,
                                    sweep_busy, sweep_done, ones_cnt}), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        done_n = 0;
        for (int t = 0; t < 140; t++) begin
            step();
            sample();
            if (sweep_done || sweep_busy || rsp_valid) done_n++;
        end
        check("no_activity_after_abort", 32'(done_n), 0);
        step();
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 200 && !seen; t++) begin
            sample();
            if (sweep_done) seen = 1'b1;
            step();
        end
        check("resweep_done", 32'(seen), 1);
        check("resweep_ones", 32'(ones_cnt), 79);

        // Randomized traffic against the transaction-level model.
        p0 = 1'b0; p1 = 1'b0; last_win = 1'b1;
        last_gnt_cyc = -10; vec_due = -1; vec_exp = '0;
        max_wait = 0; wait0 = 0; wait1 = 0;
        for (int i = 0; i < 3000; i++) rand_cycle(1'b1);
        for (int i = 0; i < 300 && (p0 || p1 || q.size() != 0); i++) rand_cycle(1'b0);
        check("rand_drained", 32'(q.size() + int'(p0) + int'(p1)), 0);
        check("rand_max_wait", 32'(max_wait < 200), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
